// File: rtl/text_row_if.sv
// Host write / beam read bundle for text_row_buffer; the command side drives
// through master, the row buffer sits on slave.
interface text_row_if #(
    parameter int CHAR_W  = 6,
    parameter int COLS    = 32,
    parameter int GLYPH_W = 8,
    parameter int GLYPH_H = 10
);
    localparam int COL_W = $clog2(COLS);
    localparam int GX_W  = $clog2(GLYPH_W);
    localparam int GY_W  = $clog2(GLYPH_H);

    logic [9:0]        xcoor;
    logic [8:0]        ycoor;
    logic              wr_en;
    logic              wr_auto;
    logic [COL_W-1:0]  wr_col;
    logic [CHAR_W-1:0] wr_data;
    logic              clr;
    logic              busy;
    logic [COL_W-1:0]  cursor;
    logic [CHAR_W-1:0] char_out;
    logic              char_valid;
    logic [GX_W-1:0]   glyph_x;
    logic [GY_W-1:0]   glyph_y;

    modport master (
        output xcoor, ycoor, wr_en, wr_auto, wr_col, wr_data, clr,
        input  busy, cursor, char_out, char_valid, glyph_x, glyph_y
    );

    modport slave (
        input  xcoor, ycoor, wr_en, wr_auto, wr_col, wr_data, clr,
        output busy, cursor, char_out, char_valid, glyph_x, glyph_y
    );
endinterface

// File: rtl/text_row_buffer.sv
// Single-row character buffer with clear sequencer, auto-increment cursor and a
// 2-cycle beam read pipeline. TEXT_ROW_IDENTITY_INIT_EN: sweep fills mem[i]=i.
module text_row_buffer #(
    parameter int                CHAR_W     = 6,
    parameter int                COLS       = 32,
    parameter int                GLYPH_W    = 8,
    parameter int                GLYPH_H    = 10,
    parameter int                X_START    = 0,
    parameter int                Y_START    = 100,
    parameter logic [CHAR_W-1:0] BLANK_CODE = '1
) (
    input logic       clk,
    input logic       rst_n,
    text_row_if.slave bus
);
    localparam int COL_W = $clog2(COLS);
    localparam int GX_W  = $clog2(GLYPH_W);
    localparam int GY_W  = $clog2(GLYPH_H);

    localparam logic signed [10:0] X0    = 11'(X_START);
    localparam logic signed [10:0] Y0    = 11'(Y_START);
    localparam logic signed [10:0] ROW_W = 11'(COLS * GLYPH_W);
    localparam logic signed [10:0] ROW_H = 11'(GLYPH_H);
    localparam logic [COL_W-1:0]   LAST  = COL_W'(COLS - 1);

    typedef enum logic {CLEAR, IDLE} state_t;

    state_t            state;
    logic              busy;
    logic [COL_W-1:0]  clr_cnt;
    logic [COL_W-1:0]  cursor;
    logic [CHAR_W-1:0] mem [COLS];
    logic [CHAR_W-1:0] fill;

    logic              col_ok;
    logic              wr_fire;
    logic [COL_W-1:0]  wr_addr;

    function automatic logic [COL_W-1:0] inc_wrap(input logic [COL_W-1:0] c);
        return (c == LAST) ? '0 : c + 1'b1;
    endfunction

`ifdef TEXT_ROW_IDENTITY_INIT_EN
    assign fill = CHAR_W'(clr_cnt);
`else
    assign fill = BLANK_CODE;
`endif

    // A clr in the same cycle as a write wins; the write is simply lost.
    assign col_ok  = {1'b0, bus.wr_col} < (COL_W + 1)'(COLS);
    assign wr_fire = (state == IDLE) && bus.wr_en && !bus.clr && (bus.wr_auto || col_ok);
    assign wr_addr = bus.wr_auto ? cursor : bus.wr_col;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= CLEAR;
            busy    <= 1'b1;
            clr_cnt <= '0;
            cursor  <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    if (bus.clr) begin
                        clr_cnt <= '0;
                    end else if (clr_cnt == LAST) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        clr_cnt <= '0;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                IDLE: begin
                    if (bus.clr) begin
                        state   <= CLEAR;
                        busy    <= 1'b1;
                        clr_cnt <= '0;
                        cursor  <= '0;
                    end else if (wr_fire) begin
                        cursor <= inc_wrap(wr_addr);
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end

    // NOTE: the character array has no reset; the CLEAR sweep after reset
    // initialises it, and resetting a RAM would stop it mapping to block memory.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[clr_cnt] <= fill;
        end else if (wr_fire) begin
            mem[wr_addr] <= bus.wr_data;
        end
    end

    // Stage 1: beam position relative to the row origin, 11-bit signed so a
    // beam left of / above the row goes negative instead of wrapping.
    logic signed [10:0] dx, dy;
    logic               in_row_d;
    logic               in_row_q;
    logic [COL_W-1:0]   col_q;
    logic [GX_W-1:0]    gx_q;
    logic [GY_W-1:0]    gy_q;

    assign dx       = $signed({1'b0, bus.xcoor}) - X0;
    assign dy       = $signed({2'b0, bus.ycoor}) - Y0;
    assign in_row_d = !dx[10] && (dx < ROW_W) && !dy[10] && (dy < ROW_H);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_row_q <= 1'b0;
            col_q    <= '0;
            gx_q     <= '0;
            gy_q     <= '0;
        end else begin
            in_row_q <= in_row_d;
            col_q    <= dx[GX_W +: COL_W];
            gx_q     <= dx[GX_W-1:0];
            gy_q     <= dy[GY_W-1:0];
        end
    end

    // Stage 2: memory read is registered here, so a same-cycle write is seen
    // only by the following read.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.char_out   <= BLANK_CODE;
            bus.char_valid <= 1'b0;
            bus.glyph_x    <= '0;
            bus.glyph_y    <= '0;
        end else if (in_row_q && !busy) begin
            bus.char_out   <= mem[col_q];
            bus.char_valid <= 1'b1;
            bus.glyph_x    <= gx_q;
            bus.glyph_y    <= gy_q;
        end else begin
            bus.char_out   <= BLANK_CODE;
            bus.char_valid <= 1'b0;
            bus.glyph_x    <= '0;
            bus.glyph_y    <= '0;
        end
    end

    assign bus.busy   = busy;
    assign bus.cursor = cursor;
endmodule

// File: tb/tb_text_row_buffer.sv
// Directed bench for text_row_buffer: reset sweep, writes, beam boundaries,
// clear sequencing; a second 20-column instance covers out-of-range wr_col.
module tb_text_row_buffer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    text_row_if #(.COLS(32)) bus ();
    text_row_if #(.COLS(20)) bus2 ();

    text_row_buffer #(.COLS(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    text_row_buffer #(.COLS(20)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    int checks = 0;
    int failures = 0;
    logic [5:0] exp_mem [32];

    typedef struct {
        logic [9:0] x;
        logic [8:0] y;
        logic       valid;
        logic [5:0] ch;
        logic [2:0] gx;
        logic [3:0] gy;
    } vec_t;
    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [5:0] fill(input int i);
`ifdef TEXT_ROW_IDENTITY_INIT_EN
        return 6'(i % 64);
`else
        return 6'h3F;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_at(input logic [9:0] x, input logic [8:0] y);
        bus.xcoor = x;
        bus.ycoor = y;
        tick();
        tick();
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (bus.busy && n < 100) begin
            tick();
            n++;
        end
    endtask

    int n;

    initial begin
        bus.xcoor = 10'd40; bus.ycoor = 9'd100;
        bus.wr_en = 1'b0; bus.wr_auto = 1'b0; bus.wr_col = '0; bus.wr_data = '0; bus.clr = 1'b0;
        bus2.xcoor = 10'd0; bus2.ycoor = 9'd0;
        bus2.wr_en = 1'b0; bus2.wr_auto = 1'b0; bus2.wr_col = '0; bus2.wr_data = '0; bus2.clr = 1'b0;

        // Reset state
        repeat (3) tick();
        check("rst_busy", 32'(bus.busy), 32'd1);
        check("rst_cursor", 32'(bus.cursor), 32'd0);
        check("rst_char", 32'(bus.char_out), 32'h3F);
        check("rst_valid", 32'(bus.char_valid), 32'd0);
        check("rst_gx", 32'(bus.glyph_x), 32'd0);
        check("rst_gy", 32'(bus.glyph_y), 32'd0);

        // Power-up sweep: busy for exactly 32 cycles after release
        rst_n = 1'b1;
        wait_idle(n);
        check("sweep_len", 32'(n), 32'd32);
        for (int i = 0; i < 32; i++) exp_mem[i] = fill(i);
        read_at(10'd40, 9'd100);
        check("sweep_col5_char", 32'(bus.char_out), 32'(fill(5)));
        check("sweep_col5_valid", 32'(bus.char_valid), 32'd1);

        // 33 auto writes wrap the cursor
        bus.wr_auto = 1'b1;
        for (int i = 0; i < 33; i++) begin
            bus.wr_en = 1'b1;
            bus.wr_data = 6'(i);
            exp_mem[i % 32] = 6'(i);
            tick();
        end
        bus.wr_en = 1'b0;
        check("auto_cursor", 32'(bus.cursor), 32'd1);
        read_at(10'd0, 9'd100);
        check("auto_mem0", 32'(bus.char_out), 32'd32);
        read_at(10'd8, 9'd100);
        check("auto_mem1", 32'(bus.char_out), 32'd1);

        // Explicit write col 7, scan its glyph row 5
        bus.wr_auto = 1'b0; bus.wr_col = 5'd7; bus.wr_data = 6'h2A; bus.wr_en = 1'b1;
        exp_mem[7] = 6'h2A;
        tick();
        bus.wr_en = 1'b0;
        check("expl_cursor", 32'(bus.cursor), 32'd8);
        for (int i = 0; i < 8; i++) begin
            read_at(10'(56 + i), 9'd105);
            check("expl_char", 32'(bus.char_out), 32'h2A);
            check("expl_gx", 32'(bus.glyph_x), 32'(i));
            check("expl_gy", 32'(bus.glyph_y), 32'd5);
            check("expl_valid", 32'(bus.char_valid), 32'd1);
        end

        // Beam boundary table
        vecs[0] = '{10'd256, 9'd100, 1'b0, 6'h3F, 3'd0, 4'd0};
        vecs[1] = '{10'd255, 9'd100, 1'b1, exp_mem[31], 3'd7, 4'd0};
        vecs[2] = '{10'd0,   9'd109, 1'b1, exp_mem[0], 3'd0, 4'd9};
        vecs[3] = '{10'd0,   9'd110, 1'b0, 6'h3F, 3'd0, 4'd0};
        vecs[4] = '{10'd0,   9'd99,  1'b0, 6'h3F, 3'd0, 4'd0};
        vecs[5] = '{10'd639, 9'd479, 1'b0, 6'h3F, 3'd0, 4'd0};
        vecs[6] = '{10'd7,   9'd100, 1'b1, exp_mem[0], 3'd7, 4'd0};
        vecs[7] = '{10'd131, 9'd103, 1'b1, exp_mem[16], 3'd3, 4'd3};
        for (int i = 0; i < 8; i++) begin
            read_at(vecs[i].x, vecs[i].y);
            check($sformatf("vec%0d_valid", i), 32'(bus.char_valid), 32'(vecs[i].valid));
            check($sformatf("vec%0d_char", i), 32'(bus.char_out), 32'(vecs[i].ch));
            check($sformatf("vec%0d_gx", i), 32'(bus.glyph_x), 32'(vecs[i].gx));
            check($sformatf("vec%0d_gy", i), 32'(bus.glyph_y), 32'(vecs[i].gy));
        end

        // Same-cycle read/write of column 3
        bus.xcoor = 10'd24; bus.ycoor = 9'd100;
        tick();
        bus.wr_col = 5'd3; bus.wr_data = 6'h15; bus.wr_en = 1'b1;
        tick();
        bus.wr_en = 1'b0;
        check("rw_old", 32'(bus.char_out), 32'(exp_mem[3]));
        tick();
        check("rw_new", 32'(bus.char_out), 32'h15);
        check("rw_cursor", 32'(bus.cursor), 32'd4);

        // clr with a simultaneous write: write dropped, full sweep
        bus.clr = 1'b1; bus.wr_en = 1'b1; bus.wr_col = 5'd9; bus.wr_data = 6'h01;
        tick();
        bus.clr = 1'b0; bus.wr_en = 1'b0;
        wait_idle(n);
        check("clr_len", 32'(n), 32'd32);
        check("clr_cursor", 32'(bus.cursor), 32'd0);
        for (int i = 0; i < 32; i++) begin
            read_at(10'(i * 8 + 2), 9'd104);
            check($sformatf("clr_col%0d", i), 32'(bus.char_out), 32'(fill(i)));
        end

        // Second clr at sweep cycle 10 restarts the count
        bus.clr = 1'b1;
        tick();
        bus.clr = 1'b0;
        n = 0;
        while (bus.busy && n < 100) begin
            bus.clr = (n == 9);
            tick();
            n++;
        end
        bus.clr = 1'b0;
        check("clr_restart_len", 32'(n), 32'd42);

        // Out-of-range explicit column on the 20-column instance
        bus2.wr_col = 5'd3; bus2.wr_data = 6'h11; bus2.wr_en = 1'b1;
        tick();
        check("oor_cursor_before", 32'(bus2.cursor), 32'd4);
        bus2.wr_col = 5'd25; bus2.wr_data = 6'h22;
        tick();
        bus2.wr_en = 1'b0;
        check("oor_cursor_after", 32'(bus2.cursor), 32'd4);
        bus2.xcoor = 10'd24; bus2.ycoor = 9'd100;
        tick();
        tick();
        check("oor_col3", 32'(bus2.char_out), 32'h11);
        bus2.xcoor = 10'd160;
        tick();
        tick();
        check("oor_x160_valid", 32'(bus2.char_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
